encout_apb_slave: RTL
=====================

ENCOUT_APB_SLAVE -- requirements
Module: encout_apb_slave

Interface
REQ-001 Parameter NREG, default 8, number of 32-bit registers served (1..32).
REQ-002 Parameter BASE_ADDR, default 32'h0091_C100, byte address of register 0; register k at BASE_ADDR + 4*k.
REQ-003 Parameter WAIT_STATES, default 0, extra ACCESS cycles inserted before o_pready (0..15).
REQ-004 Parameter RO_MASK, default 0 (NREG bits), bit k = 1 marks register k read-only.
REQ-005 i_pclk  in  1  sole clock; all state on rising edge.
REQ-006 i_presetn  in  1  asynchronous active-low reset.
REQ-007 i_paddr  in  32  APB byte address.
REQ-008 i_psel, i_penable, i_pwrite  in  1 each  APB3 control.
REQ-009 i_pwdata  in  32  APB write data.
REQ-010 o_pready  out  1  transfer complete; o_pslverr  out  1  transfer error, valid only with o_pready.
REQ-011 o_prdata  out  32  registered read data.
REQ-012 o_we  out  NREG  one-hot write strobe to register block; o_wdata  out  32  write data.
REQ-013 o_re  out  NREG  one-hot read strobe; i_rdata  in  32  register-block read data, valid combinationally in the cycle o_re is high.

Function
REQ-014 The FSM SHALL have states IDLE and ACCESS.
REQ-015 In IDLE, a setup cycle (i_psel & ~i_penable) SHALL latch write flag, i_pwdata, hit, index and error, load the wait counter, and move to ACCESS.
REQ-016 Hit SHALL be (i_paddr - BASE_ADDR) < 4*NREG with i_paddr[1:0] == 0, using unsigned 32-bit wrap-around subtraction; index = (i_paddr - BASE_ADDR) >> 2.
REQ-017 Error SHALL be set for a miss, a misaligned address, or a write to a register with RO_MASK bit set.
REQ-018 Wait counter load SHALL be WAIT_STATES for writes and errors, and max(WAIT_STATES,1) for error-free reads.
REQ-019 In ACCESS the counter SHALL decrement by 1 per cycle while nonzero; o_pready SHALL be 1 exactly when state is ACCESS and counter is 0, else 0.
REQ-020 o_pslverr SHALL equal o_pready & latched error.
REQ-021 Error-free read: o_re[index] SHALL pulse high for exactly one cycle, the first ACCESS cycle; o_prdata SHALL capture i_rdata at the end of that cycle and hold until the next error-free read.
REQ-022 Error read SHALL leave o_re at 0 and load o_prdata with 0.
REQ-023 Error-free write: o_we[index] SHALL pulse high for one cycle, the cycle after the completing ACCESS cycle; o_wdata SHALL hold the latched data from that setup until the next write setup.
REQ-024 Error write SHALL leave o_we at 0.
REQ-025 On o_pready & i_penable & i_psel, FSM SHALL return to IDLE; the next setup cycle is accepted from IDLE (back-to-back transfer, no bubble beyond APB protocol).
REQ-026 If i_psel falls while in ACCESS before completion, FSM SHALL abort to IDLE with no pending o_we/o_re issued afterward.
REQ-027 At most one bit of o_we|o_re SHALL be high in any cycle.

Reset
REQ-028 While i_presetn is 0: state IDLE, counter 0, o_pready 0, o_pslverr 0, o_prdata 0, o_wdata 0, o_we 0, o_re 0, all latches 0.
REQ-029 Reset asserted mid-transfer SHALL drop strobes immediately; no strobe SHALL be emitted for that transfer after release.

Structure
REQ-030 Package encout_apb_pkg SHALL hold the state enumeration, default BASE_ADDR, and WAIT_STATES maximum (15).
REQ-031 Sub-module encout_apb_decode (combinational: address, write flag -> hit, index, error) SHALL be instantiated once.

Verification
REQ-032 Defaults, write 32'hA5A5_0001 to 32'h0091_C108 -> o_pready in first ACCESS cycle, o_we = 8'b0000_0100 one cycle later, o_wdata = 32'hA5A5_0001.
REQ-033 Defaults, read 32'h0091_C10C with i_rdata = 32'h1234 -> o_re = 8'b0000_1000 in ACCESS cycle 1, o_pready in cycle 2, o_prdata = 32'h1234.
REQ-034 WAIT_STATES = 3, write -> o_pready low for 3 ACCESS cycles, high on the 4th.
REQ-035 Read 32'h0091_C120 (miss) and 32'h0091_C102 (misaligned) -> o_pslverr = 1 with o_pready, o_re = 0, o_prdata = 0.
REQ-036 RO_MASK = 8'h01, write 32'h0091_C100 -> o_pslverr = 1, o_we = 0; read of same address -> no error.
REQ-037 Assert i_presetn = 0 during ACCESS of a read with WAIT_STATES = 2 -> all outputs 0 immediately, no o_re after release.

Source files
------------

// File: rtl/encout_apb_pkg.sv
// Shared types and constants for the encout APB register slave.
// State encoding, default base address, wait-state ceiling.
package encout_apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h0091_C100;
  localparam int          WAIT_MAX      = 15;

endpackage

// File: rtl/encout_apb_decode.sv
// Address decode: window hit, register index, transfer error.
// Offset uses unsigned 32-bit wrap so addresses below base miss.
module encout_apb_decode
  import encout_apb_pkg::*;
#(
  parameter int               NREG      = 8,
  parameter logic [31:0]      BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [NREG-1:0]  RO_MASK   = '0
) (
  input  logic [31:0] paddr,
  input  logic        write,
  output logic        hit,
  output logic [4:0]  idx,
  output logic        err
);

  logic [31:0] off;
  logic [31:0] ro;

  assign off = paddr - BASE_ADDR;
  assign ro  = 32'(RO_MASK);

  assign hit = (off < 32'(4 * NREG))
            && (paddr[1:0] == 2'b00);
  assign idx = off[6:2];
  assign err = !hit || (write && ro[idx]);

endmodule

// File: rtl/encout_apb_slave.sv
// APB3 slave fronting a register block with one-hot strobes.
// Reads strobe in the first ACCESS cycle; writes after completion.
module encout_apb_slave
  import encout_apb_pkg::*;
#(
  parameter int               NREG        = 8,
  parameter logic [31:0]      BASE_ADDR   = DEF_BASE_ADDR,
  parameter int               WAIT_STATES = 0,
  parameter logic [NREG-1:0]  RO_MASK     = '0
) (
  input  logic            i_pclk,
  input  logic            i_presetn,
  input  logic [31:0]     i_paddr,
  input  logic            i_psel,
  input  logic            i_penable,
  input  logic            i_pwrite,
  input  logic [31:0]     i_pwdata,
  output logic            o_pready,
  output logic            o_pslverr,
  output logic [31:0]     o_prdata,
  output logic [NREG-1:0] o_we,
  output logic [31:0]     o_wdata,
  output logic [NREG-1:0] o_re,
  input  logic [31:0]     i_rdata
);

  localparam int WS_CLAMP =
    (WAIT_STATES > WAIT_MAX) ? WAIT_MAX : WAIT_STATES;
  localparam logic [3:0] WS    = 4'(WS_CLAMP);
  localparam logic [3:0] WS_RD = (WS_CLAMP == 0) ? 4'd1 : WS;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        wr_q, hit_q, err_q;
  logic [4:0]  idx_q;

  logic        hit, err;
  logic [4:0]  idx;
  logic        setup, done;

  encout_apb_decode #(
    .NREG      (NREG),
    .BASE_ADDR (BASE_ADDR),
    .RO_MASK   (RO_MASK)
  ) u_decode (
    .paddr (i_paddr),
    .write (i_pwrite),
    .hit   (hit),
    .idx   (idx),
    .err   (err)
  );

  assign setup = (state == IDLE) && i_psel && !i_penable;
  assign o_pready  = (state == ACCESS) && (cnt == 4'd0);
  assign o_pslverr = o_pready && err_q;
  assign done      = o_pready && i_psel && i_penable;

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (setup) state_nxt = ACCESS;
      ACCESS: if (!i_psel || done) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      cnt      <= '0;
      wr_q     <= 1'b0;
      hit_q    <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      o_prdata <= '0;
      o_wdata  <= '0;
      o_we     <= '0;
      o_re     <= '0;
    end else begin
      o_re <= '0;
      o_we <= '0;
      if (setup) begin
        wr_q  <= i_pwrite;
        hit_q <= hit;
        idx_q <= idx;
        err_q <= err;
        cnt   <= (i_pwrite || err) ? WS : WS_RD;
        if (i_pwrite)
          o_wdata <= i_pwdata;
        if (!i_pwrite && !err)
          o_re <= NREG'(1) << idx;
        if (!i_pwrite && err)
          o_prdata <= '0;
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // o_re is only ever set from IDLE, so this never meets setup
      if (|o_re)
        o_prdata <= i_rdata;
      if (done && wr_q && hit_q && !err_q)
        o_we <= NREG'(1) << idx_q;
    end
  end

endmodule
